// File: rtl/fifo_pop_ctrl.sv
// Read-side drain stage: pops the FIFO into a 2-entry skid buffer.
// Optional pop_count port and counter: define POP_CTRL_CNT_EN.
module fifo_pop_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out,
    input  logic                  FIFO_empty,
    input  logic                  FIFO_almost_empty,
    input  logic                  data_ready,
    output logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid
`ifdef POP_CTRL_CNT_EN
    ,
    output logic [15:0]           pop_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]            occ;
    logic [1:0]            occ_nxt;
    logic                  inflight;
    logic                  deq;
    logic [2:0]            committed;
    logic [1:0]            tail;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic [DATA_WIDTH-1:0] buf0_nxt;
    logic [DATA_WIDTH-1:0] buf1_nxt;

    assign data_valid = (occ != 2'd0);
    assign data_out   = buf0;
    assign deq        = data_valid & data_ready;

    // Words owned after this cycle: buffered plus in flight, minus the one leaving.
    assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};

    // Flags are one pop stale, so a lone remaining word must not be popped twice.
    assign read_enable = (state == RUN)
                       & ~FIFO_empty
                       & (committed < 3'd2)
                       & ~(FIFO_almost_empty & inflight);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (Enable) state_nxt = RUN;
            end
            RUN: begin
                if (!Enable)                state_nxt = IDLE;
                else if (committed == 3'd2) state_nxt = HOLD;
            end
            HOLD: begin
                if (!Enable)  state_nxt = IDLE;
                else if (deq) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign occ_nxt = occ + {1'b0, inflight} - {1'b0, deq};
    assign tail    = occ - {1'b0, deq};

    // Shift on dequeue first; a capture into slot 0 overrides the shift.
    always_comb begin
        buf0_nxt = buf0;
        buf1_nxt = buf1;
        if (deq) buf0_nxt = buf1;
        if (inflight) begin
            if (tail == 2'd0) buf0_nxt = FIFO_data_out;
            else              buf1_nxt = FIFO_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            state    <= state_nxt;
            occ      <= occ_nxt;
            inflight <= read_enable;
            buf0     <= buf0_nxt;
            buf1     <= buf1_nxt;
        end
    end

`ifdef POP_CTRL_CNT_EN
    always_ff @(posedge clk) begin
        if (Reset)    pop_count <= 16'd0;
        else if (deq) pop_count <= pop_count + 16'd1;
    end
`endif

    a_no_overflow: assert property (
        @(posedge clk) disable iff (Reset)
        !(inflight && (occ == 2'd2) && !deq)
    );

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: queue-based FIFO plus behavioural reference.
// Covers the optional pop_count port when POP_CTRL_CNT_EN is defined.
module tb_fifo_pop_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          Reset;
    logic          Enable;
    logic [DW-1:0] FIFO_data_out;
    logic          FIFO_empty;
    logic          FIFO_almost_empty;
    logic          data_ready;
    logic          read_enable;
    logic [DW-1:0] data_out;
    logic          data_valid;
`ifdef POP_CTRL_CNT_EN
    logic [15:0]   pop_count;
`endif

    always #5 clk = ~clk;

    fifo_pop_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .Enable           (Enable),
        .FIFO_data_out    (FIFO_data_out),
        .FIFO_empty       (FIFO_empty),
        .FIFO_almost_empty(FIFO_almost_empty),
        .data_ready       (data_ready),
        .read_enable      (read_enable),
        .data_out         (data_out),
        .data_valid       (data_valid)
`ifdef POP_CTRL_CNT_EN
        ,
        .pop_count        (pop_count)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] fq[$];
    logic [7:0] mf[$];
    logic [7:0] mbuf[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    bit          m_infl;
    logic [7:0]  m_infl_w;
    int          m_mode;
    logic [15:0] m_cnt;
    bit          exp_re;
    bit          exp_valid;
    bit          m_deq;
    logic [7:0]  exp_data;

    bit re_s;
    int cyc      = 0;
    int cnt_re   = 0;
    int first_re = -1;
    int first_dq = -1;
    int last_dq  = -1;
    int max_gap  = 0;
    int c0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h",
                     name, act, exp);
        end
    endtask

    task automatic chk_seq(input string name);
        chk({name, "_len"}, got.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got.size()) chk(name, got[i], exp_q[i]);
    endtask

    task automatic load(input logic [7:0] w);
        fq.push_back(w);
        mf.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic clear_stats();
        cnt_re   = 0;
        first_re = -1;
        first_dq = -1;
        last_dq  = -1;
        max_gap  = 0;
        got.delete();
        exp_q.delete();
    endtask

    // Effects of the clock edge just taken, from the pre-edge values.
    task automatic edge_update();
        int sz;
        if (Reset) begin
            fq.delete();
            mf.delete();
            mbuf.delete();
            m_infl            = 1'b0;
            m_mode            = 0;
            m_cnt             = 16'd0;
            FIFO_empty        = 1'b1;
            FIFO_almost_empty = 1'b1;
            FIFO_data_out     = '0;
        end else begin
            FIFO_empty        = (fq.size() == 0);
            FIFO_almost_empty = (fq.size() <= 1);
            if (re_s && fq.size() > 0) FIFO_data_out = fq.pop_front();
            sz = mbuf.size() + int'(m_infl) - int'(m_deq);
            case (m_mode)
                0: if (Enable) m_mode = 1;
                1: begin
                    if (!Enable)      m_mode = 0;
                    else if (sz == 2) m_mode = 2;
                end
                default: begin
                    if (!Enable)   m_mode = 0;
                    else if (m_deq) m_mode = 1;
                end
            endcase
            if (m_deq) begin
                void'(mbuf.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (m_infl) mbuf.push_back(m_infl_w);
            m_infl = exp_re;
            if (exp_re && mf.size() > 0) m_infl_w = mf.pop_front();
        end
    endtask

    task automatic compute_exp();
        m_deq     = (mbuf.size() > 0) && data_ready;
        exp_valid = (mbuf.size() > 0);
        exp_data  = exp_valid ? mbuf[0] : 8'h00;
        exp_re    = (m_mode == 1) && !FIFO_empty
                 && (mbuf.size() + int'(m_infl) - int'(m_deq) < 2)
                 && !(FIFO_almost_empty && m_infl);
    endtask

    task automatic compare_cycle();
        cyc++;
        if (!Reset) begin
            chk("read_enable", read_enable, exp_re);
            chk("data_valid", data_valid, exp_valid);
            if (exp_valid) chk("data_out", data_out, exp_data);
`ifdef POP_CTRL_CNT_EN
            chk("pop_count", pop_count, m_cnt);
`endif
            if (read_enable) begin
                cnt_re++;
                if (first_re < 0) first_re = cyc;
            end
            if (data_valid && data_ready) begin
                got.push_back(data_out);
                if (first_dq < 0) first_dq = cyc;
                if (last_dq >= 0 && cyc - last_dq > max_gap)
                    max_gap = cyc - last_dq;
                last_dq = cyc;
            end
        end
        re_s = read_enable;
    endtask

    task automatic tick(input bit en, input bit rdy, input bit rst);
        @(posedge clk);
        #1;
        edge_update();
        Enable     = en;
        data_ready = rdy;
        Reset      = rst;
        compute_exp();
        @(negedge clk);
        compare_cycle();
    endtask

    initial begin
        Reset             = 1'b1;
        Enable            = 1'b0;
        data_ready        = 1'b0;
        FIFO_empty        = 1'b1;
        FIFO_almost_empty = 1'b1;
        FIFO_data_out     = '0;
        m_mode            = 0;
        m_cnt             = 16'd0;
        m_infl            = 1'b0;
        m_infl_w          = 8'h00;
        m_deq             = 1'b0;
        exp_re            = 1'b0;
        re_s              = 1'b0;

        repeat (3) tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_re", read_enable, 1'b0);
        chk("rst_data", data_out, 8'h00);
`ifdef POP_CTRL_CNT_EN
        chk("rst_cnt", pop_count, 16'd0);
`endif

        clear_stats();
        load(8'h11); load(8'h22); load(8'h33);
        repeat (12) tick(1'b1, 1'b1, 1'b0);
        chk("t1_pops", cnt_re, 3);
        chk("t1_latency", first_dq - first_re, 2);
        chk("t1_span", last_dq - first_dq, 2);
        chk_seq("t1_data");
`ifdef POP_CTRL_CNT_EN
        chk("t1_cnt", pop_count, 16'd3);
`endif

        clear_stats();
        load(8'hA5);
        repeat (10) tick(1'b1, 1'b1, 1'b0);
        chk("t2_pops", cnt_re, 1);
        chk_seq("t2_data");

        clear_stats();
        for (int i = 0; i < 6; i++) load(8'h60 + 8'(i));
        repeat (10) tick(1'b1, 1'b0, 1'b0);
        chk("t3_pops_held", cnt_re, 2);
        chk("t3_valid_held", data_valid, 1'b1);
        chk("t3_head_held", data_out, 8'h60);
        repeat (20) tick(1'b1, 1'b1, 1'b0);
        chk("t3_pops", cnt_re, 6);
        chk("t3_gap_ok", (max_gap <= 2), 1'b1);
        chk_seq("t3_data");

        clear_stats();
        for (int i = 0; i < 8; i++) load(8'h80 + 8'(i));
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        c0 = cnt_re;
        repeat (6) tick(1'b0, 1'b1, 1'b0);
        chk("t4_no_pop", cnt_re - c0, 0);
        chk("t4_drained", got.size(), cnt_re);
        repeat (15) tick(1'b1, 1'b1, 1'b0);
        chk_seq("t4_data");

        clear_stats();
        for (int i = 0; i < 6; i++) load(8'hC0 + 8'(i));
        repeat (8) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        chk("t5_valid", data_valid, 1'b0);
        chk("t5_re", read_enable, 1'b0);
`ifdef POP_CTRL_CNT_EN
        chk("t5_cnt", pop_count, 16'd0);
`endif
        repeat (6) tick(1'b1, 1'b1, 1'b0);
        load(8'hD0); load(8'hD1); load(8'hD2); load(8'hD3);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        chk("t5b_valid", data_valid, 1'b0);
        chk("t5b_re", read_enable, 1'b0);
        repeat (8) tick(1'b1, 1'b1, 1'b0);
        chk("t5_no_stale", got.size(), 0);

        clear_stats();
        for (int i = 0; i < 10; i++) load(8'h30 + 8'(i));
        for (int i = 0; i < 40; i++) tick(1'b1, (i % 2) == 0, 1'b0);
        chk("t6_pops", cnt_re, 10);
        chk_seq("t6_data");
`ifdef POP_CTRL_CNT_EN
        chk("t6_cnt", pop_count, 16'd10);
`endif

        clear_stats();
        for (int i = 0; i < 800; i++) begin
            tick(($urandom % 8) != 0, $urandom % 2,
                 ($urandom % 200) == 0);
            if (($urandom % 3) == 0 && fq.size() < 8)
                load(8'($urandom));
        end
        repeat (30) tick(1'b1, 1'b1, 1'b0);
        chk("rand_fifo_drained", fq.size(), 0);
        chk("rand_buf_empty", data_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
